spi_cmd_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares one SPI master transaction engine (32-bit full-duplex shift, CSN-framed, slow divided SCLK) between NUM_REQ on-chip requesters.
- Latches the granted requester's command and drives START to the master.
- Tracks the transaction by monitoring the master's chip-select output, then returns the captured MISO word to the requester with a one-cycle DONE pulse.
- Also owns a timeout watchdog and enforces an inter-transaction gap, so the master is back in its idle state before the next START.

---
 rtl/spi_cmd_arbiter.sv | 123 ++++++++++++
 tb/tb_spi_cmd_arbiter.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/spi_cmd_arbiter.sv
// Round-robin arbiter that shares one SPI master between NUM_REQ requesters,
// tracking each transaction via looped-back CSN with a timeout and an idle gap.
module spi_cmd_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int CMD_W       = 32,
  parameter int TIMEOUT_CYC = 4096,
  parameter int GAP_CYC     = 32
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic [NUM_REQ-1:0]       REQ,
  input  logic [NUM_REQ*CMD_W-1:0] REQ_CMD,
  output logic [NUM_REQ-1:0]       GNT,
  output logic [NUM_REQ-1:0]       DONE,
  output logic [CMD_W-1:0]         RSP_DATA,
  output logic                     RSP_ERR,
  output logic                     BUSY,
  output logic                     SPI_START,
  output logic [CMD_W-1:0]         SPI_CMD,
  input  logic [CMD_W-1:0]         SPI_MISO_DATA,
  input  logic                     SPI_CSN_MON
);
  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int TO_W  = $clog2(TIMEOUT_CYC);
  localparam int GAP_W = $clog2(GAP_CYC);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [TO_W-1:0]  TO_FIRE  = TO_W'(TIMEOUT_CYC - 2);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_REQ - 1);

  typedef enum logic [2:0] {IDLE, LAUNCH, ACTIVE, RECOVER, GAP} state_t;

  state_t            state;
  logic [1:0]        csn_q;
  logic              csn_s;
  logic [PTR_W-1:0]  ptr, win;
  logic [TO_W-1:0]   to_cnt;
  logic [GAP_W-1:0]  gap_cnt;
  int                j;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) csn_q <= 2'b11;
    else        csn_q <= {csn_q[0], SPI_CSN_MON};
  end
  assign csn_s = csn_q[1];

  // Scan downward so the last match, the one closest to ptr, wins.
  always_comb begin
    win = '0;
    j   = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      j = (int'(ptr) + k) % NUM_REQ;
      if (REQ[j]) win = PTR_W'(j);
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= IDLE;
      GNT       <= '0;
      DONE      <= '0;
      RSP_DATA  <= '0;
      RSP_ERR   <= 1'b0;
      BUSY      <= 1'b0;
      SPI_START <= 1'b0;
      SPI_CMD   <= '0;
      ptr       <= '0;
      to_cnt    <= '0;
      gap_cnt   <= '0;
    end else begin
      DONE <= '0;
      case (state)
        IDLE: if (|REQ) begin
          GNT       <= NUM_REQ'(1) << win;
          SPI_CMD   <= REQ_CMD[int'(win)*CMD_W +: CMD_W];
          SPI_START <= 1'b1;
          ptr       <= (win == PTR_LAST) ? '0 : win + PTR_W'(1);
          to_cnt    <= '0;
          BUSY      <= 1'b1;
          state     <= LAUNCH;
        end
        LAUNCH, ACTIVE: begin
          // Timeout outranks the CSN edges seen in the same cycle.
          if (to_cnt == TO_FIRE) begin
            SPI_START <= 1'b0;
            DONE      <= GNT;
            RSP_ERR   <= 1'b1;
            RSP_DATA  <= '0;
            GNT       <= '0;
            state     <= RECOVER;
          end else begin
            if (to_cnt != TO_LAST) to_cnt <= to_cnt + TO_W'(1);
            if (state == LAUNCH && !csn_s) begin
              SPI_START <= 1'b0;
              state     <= ACTIVE;
            end else if (state == ACTIVE && csn_s) begin
              RSP_DATA  <= SPI_MISO_DATA;
              RSP_ERR   <= 1'b0;
              DONE      <= GNT;
              GNT       <= '0;
              SPI_START <= 1'b0;
              gap_cnt   <= '0;
              state     <= GAP;
            end
          end
        end
        RECOVER: if (csn_s) begin
          gap_cnt <= '0;
          state   <= GAP;
        end
        GAP: begin
          // Any CSN-low blip restarts the idle window.
          if (!csn_s)                   gap_cnt <= '0;
          else if (gap_cnt == GAP_LAST) begin
            BUSY  <= 1'b0;
            state <= IDLE;
          end else                      gap_cnt <= gap_cnt + GAP_W'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_cmd_arbiter.sv
// Directed bench for spi_cmd_arbiter with a behavioural SPI master that
// frames CSN after START and returns the command with its halves swapped.
module tb_spi_cmd_arbiter;
  localparam int NR = 4, CW = 32, TO = 64, GP = 8;

  logic          CLK = 1'b0, RST_N = 1'b0;
  logic [NR-1:0] REQ = '0;
  logic [NR*CW-1:0] REQ_CMD = '0;
  logic [NR-1:0] GNT, DONE;
  logic [CW-1:0] RSP_DATA, SPI_CMD;
  logic [CW-1:0] SPI_MISO_DATA = '0;
  logic          RSP_ERR, BUSY, SPI_START;
  logic          csn = 1'b1;

  int n_chk = 0, n_pass = 0, cyc = 0, oh_err = 0;
  int m_mode = 1;
  bit m_release = 0;
  int csn_fall_cyc = 0, csn_rise_cyc = 0;
  logic start_f1 = 1'b0, start_f3 = 1'b1;
  logic [CW-1:0] m_cmd;
  logic [CW-1:0] cmd_tab [NR] = '{32'hA5A5_0F0F, 32'h0123_4567, 32'h89AB_CDEF, 32'hDEAD_BEEF};
  logic [CW-1:0] rsp_tab [NR] = '{32'h0F0F_A5A5, 32'h4567_0123, 32'hCDEF_89AB, 32'hBEEF_DEAD};

  spi_cmd_arbiter #(.NUM_REQ(NR), .CMD_W(CW), .TIMEOUT_CYC(TO), .GAP_CYC(GP)) dut (
    .CLK(CLK), .RST_N(RST_N), .REQ(REQ), .REQ_CMD(REQ_CMD), .GNT(GNT), .DONE(DONE),
    .RSP_DATA(RSP_DATA), .RSP_ERR(RSP_ERR), .BUSY(BUSY), .SPI_START(SPI_START),
    .SPI_CMD(SPI_CMD), .SPI_MISO_DATA(SPI_MISO_DATA), .SPI_CSN_MON(csn)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;
  always @(negedge CLK) if ((GNT != '0 && !$onehot(GNT)) || (DONE != '0 && !$onehot(DONE))) oh_err++;

  // Master model: mode 0 absent, 1 normal, 2 hold CSN low until released.
  initial begin
    forever begin
      @(negedge CLK);
      if (m_mode != 0 && SPI_START && csn && RST_N) begin
        m_cmd = SPI_CMD;
        repeat (2) @(negedge CLK);
        csn = 1'b0; csn_fall_cyc = cyc;
        @(negedge CLK); start_f1 = SPI_START;
        repeat (2) @(negedge CLK); start_f3 = SPI_START;
        if (m_mode == 2) while (!m_release) @(negedge CLK);
        else repeat (7) @(negedge CLK);
        SPI_MISO_DATA = {m_cmd[15:0], m_cmd[31:16]};
        csn = 1'b1; csn_rise_cyc = cyc;
        repeat (4) @(negedge CLK);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  function automatic int oh2i(input logic [NR-1:0] v);
    int r = -1;
    for (int i = 0; i < NR; i++) if (v[i]) r = i;
    return r;
  endfunction

  task automatic do_reset();
    RST_N = 1'b0; REQ = '0; m_release = 0;
    repeat (5) @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
  endtask

  task automatic wait_gnt(input int budget, output int idx, output int at);
    idx = -1; at = cyc;
    for (int i = 0; i < budget; i++) begin
      @(negedge CLK);
      if (GNT != '0) begin idx = oh2i(GNT); at = cyc; return; end
    end
    chk("gnt_timeout", 1, 0);
  endtask

  task automatic wait_done(input int budget, output int idx, output int at);
    idx = -1; at = cyc;
    for (int i = 0; i < budget; i++) begin
      @(negedge CLK);
      if (DONE != '0) begin idx = oh2i(DONE); at = cyc; return; end
    end
    chk("done_timeout", 1, 0);
  endtask

  task automatic wait_active(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge CLK);
      if (!SPI_START) return;
    end
    chk("active_timeout", 1, 0);
  endtask

  task automatic wait_idle(input int budget, output int at);
    at = cyc;
    for (int i = 0; i < budget; i++) begin
      @(negedge CLK);
      if (!BUSY) begin at = cyc; return; end
    end
    chk("idle_timeout", 1, 0);
  endtask

  initial begin
    int g, gc, d, dc, ic;
    bit done_seen;
    for (int i = 0; i < NR; i++) REQ_CMD[i*CW +: CW] = cmd_tab[i];

    // Reset values and single request
    do_reset();
    chk("rst_gnt", GNT, 0);  chk("rst_done", DONE, 0); chk("rst_rsp", RSP_DATA, 0);
    chk("rst_err", RSP_ERR, 0); chk("rst_busy", BUSY, 0); chk("rst_start", SPI_START, 0);
    chk("rst_cmd", SPI_CMD, 0);
    REQ = 4'b0001;
    @(negedge CLK);
    chk("t1_gnt", GNT, 4'b0001); chk("t1_start", SPI_START, 1);
    chk("t1_cmd", SPI_CMD, 32'hA5A5_0F0F); chk("t1_busy", BUSY, 1);
    wait_done(100, d, dc);
    chk("t1_done_idx", d, 0); chk("t1_rsp", RSP_DATA, 32'h0F0F_A5A5); chk("t1_err", RSP_ERR, 0);
    chk("t1_gnt_clr", GNT, 0); chk("t1_done_lat", dc - csn_rise_cyc, 3);
    chk("t1_start_f1", start_f1, 1); chk("t1_start_f3", start_f3, 0);
    REQ = '0;
    @(negedge CLK);
    chk("t1_pulse", DONE, 0); chk("t1_rsp_hold", RSP_DATA, 32'h0F0F_A5A5);

    // All requesters: rotation and enforced gap
    do_reset();
    REQ = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      wait_gnt(200, g, gc);
      chk("t2_gnt", g, n % NR);
      if (n > 0) chk("t2_gap", gc - dc, GP + 1);
      wait_done(200, d, dc);
      chk("t2_done", d, n % NR); chk("t2_rsp", RSP_DATA, rsp_tab[n % NR]);
    end
    REQ = '0;

    // Requester 2 drops mid-transaction, others change, command changes
    do_reset();
    REQ = 4'b0100;
    wait_gnt(100, g, gc); chk("t3_gnt", g, 2);
    wait_active(100);
    REQ = 4'b1001; REQ_CMD[2*CW +: CW] = 32'h0BAD_0BAD;
    @(negedge CLK);
    chk("t3_cmd_hold", SPI_CMD, cmd_tab[2]);
    wait_done(100, d, dc); chk("t3_done", d, 2); chk("t3_rsp", RSP_DATA, rsp_tab[2]);
    REQ_CMD[2*CW +: CW] = cmd_tab[2];
    wait_gnt(100, g, gc); chk("t3_next", g, 3);
    wait_done(100, d, dc); chk("t3_done3", d, 3); chk("t3_rsp3", RSP_DATA, rsp_tab[3]);
    REQ = 4'b0001;
    wait_gnt(100, g, gc); chk("t3_wrap", g, 0);
    wait_done(100, d, dc); chk("t3_done0", d, 0);
    REQ = '0;
    wait_idle(100, ic);

    // Timeout with master absent (pointer now at 1)
    m_mode = 0;
    REQ = 4'b0010;
    wait_gnt(100, g, gc); chk("t4_gnt", g, 1); chk("t4_err_pre", RSP_ERR, 0);
    wait_done(200, d, dc);
    chk("t4_done", d, 1); chk("t4_lat", dc - gc, TO - 1); chk("t4_err", RSP_ERR, 1);
    chk("t4_rsp", RSP_DATA, 0); chk("t4_gnt_clr", GNT, 0); chk("t4_start", SPI_START, 0);
    REQ = '0;
    wait_idle(200, ic); chk("t4_idle", ic - dc, GP + 1);

    // Timeout with CSN stuck low, then release
    m_mode = 2;
    REQ = 4'b0001;
    wait_gnt(100, g, gc); chk("t5_gnt", g, 0);
    wait_done(200, d, dc); chk("t5_done", d, 0); chk("t5_err", RSP_ERR, 1); chk("t5_lat", dc - gc, TO - 1);
    REQ = '0;
    repeat (20) @(negedge CLK);
    chk("t5_busy", BUSY, 1); chk("t5_start", SPI_START, 0); chk("t5_gnt", GNT, 0);
    m_release = 1;
    wait_idle(200, ic); chk("t5_idle", ic - csn_rise_cyc, GP + 3);
    m_release = 0; m_mode = 1;

    // Reset during ACTIVE
    do_reset();
    REQ = 4'b0010;
    wait_gnt(100, g, gc); chk("t6_gnt", g, 1);
    wait_active(100);
    @(negedge CLK);
    RST_N = 1'b0;
    #1;
    chk("t6_gnt", GNT, 0); chk("t6_start", SPI_START, 0); chk("t6_busy", BUSY, 0);
    chk("t6_done", DONE, 0); chk("t6_cmd", SPI_CMD, 0);
    REQ = '0; done_seen = 0;
    repeat (15) begin @(negedge CLK); if (DONE != '0) done_seen = 1; end
    chk("t6_no_done", done_seen, 0);
    RST_N = 1'b1;
    @(negedge CLK);
    REQ = 4'b0101;
    wait_gnt(100, g, gc); chk("t6_ptr_rst", g, 0);
    wait_done(100, d, dc); chk("t6_done0", d, 0);
    REQ = '0;

    chk("onehot", oh_err, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
